hidden_neuron_mac: RTL and testbench

Sequential multiply-accumulate engine for one target-net neuron. It sits directly downstream of the weight RAMs and the layer input buffer. On a start pulse it streams addresses `0..len-1` to both memories and accumulates `x[k]*w[k]` in signed fixed point. It then adds the neuron bias, optionally applies ReLU, and presents one saturated result word to the next layer.

---
 rtl/hidden_neuron_mac_if.sv | 29 ++
 rtl/hidden_neuron_mac.sv | 157 +++++++++++++++
 tb/tb_hidden_neuron_mac.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/hidden_neuron_mac_if.sv
// Bus bundle between the neuron MAC, its feeding memories and the next layer.
// The slave side is the MAC itself; the master side is whatever drives the
// operands, services the reads and consumes the result.
interface hidden_neuron_mac_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_BITS  = 5
);
  logic                  i_start;
  logic [ADDR_BITS:0]    i_len;
  logic [DATA_WIDTH-1:0] i_bias;
  logic                  o_rd_en;
  logic [ADDR_BITS-1:0]  o_rd_addr;
  logic [DATA_WIDTH-1:0] i_w_data;
  logic [DATA_WIDTH-1:0] i_x_data;
  logic                  o_busy;
  logic                  o_valid;
  logic [DATA_WIDTH-1:0] o_data;
  logic                  o_sat;

  modport slave (
    input  i_start, i_len, i_bias, i_w_data, i_x_data,
    output o_rd_en, o_rd_addr, o_busy, o_valid, o_data, o_sat
  );

  modport master (
    output i_start, i_len, i_bias, i_w_data, i_x_data,
    input  o_rd_en, o_rd_addr, o_busy, o_valid, o_data, o_sat
  );
endinterface

// File: rtl/hidden_neuron_mac.sv
// Sequential multiply-accumulate for one hidden neuron: streams len addresses
// to the weight RAM and input buffer, accumulates x*w at full precision,
// adds the bias, rescales, saturates, optionally applies ReLU.
module hidden_neuron_mac #(
  parameter int DATA_WIDTH = 32,
  parameter int FRAC_BITS  = 16,
  parameter int ADDR_BITS  = 5,
  parameter int RELU       = 1
) (
  input logic            clk,
  input logic            rst_n,
  hidden_neuron_mac_if.slave bus
);

  localparam int LEN_W  = ADDR_BITS + 1;
  localparam int PROD_W = 2 * DATA_WIDTH;
  localparam int ACC_W  = PROD_W + ADDR_BITS + 1;

  // Saturation bounds of the output word, widened to accumulator width.
  localparam logic signed [ACC_W-1:0] SAT_MAX =
    {{(ACC_W-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN =
    {{(ACC_W-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_READ, S_WAIT, S_FINAL} state_e;

  state_e state_q, state_d;

  logic [LEN_W-1:0]        len_q, len_d;
  logic [DATA_WIDTH-1:0]   bias_q, bias_d;
  logic [ADDR_BITS-1:0]    addr_q, addr_d;
  logic                    rd_en_dly_q, rd_en_dly_d;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic [DATA_WIDTH-1:0]   data_q, data_d;
  logic                    sat_q, sat_d;
  logic                    valid_q, valid_d;

  logic rd_en;
  logic accept;
  logic last_addr;

  logic signed [PROD_W-1:0] x_ext, w_ext, prod;
  logic signed [ACC_W-1:0]  bias_ext, biased, shifted;
  logic [DATA_WIDTH-1:0]    res;
  logic                     res_sat;

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the values from before the edge, independent of block order.
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic and read strobe.
  // NOTE: every signal written here gets a default first, so no path through
  // the case leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d   = state_q;
    rd_en     = 1'b0;
    accept    = 1'b0;
    last_addr = ({1'b0, addr_q} == (len_q - LEN_W'(1)));
    case (state_q)
      S_IDLE: begin
        if (bus.i_start) begin
          accept  = 1'b1;
          state_d = (bus.i_len != '0) ? S_READ : S_WAIT;
        end
      end
      S_READ: begin
        rd_en = 1'b1;
        if (last_addr) state_d = S_WAIT;
      end
      S_WAIT:  state_d = S_FINAL;
      S_FINAL: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Final scaling: add bias aligned to the product scale, drop the extra
  // fraction bits (floor), clamp to the output word, then optional ReLU.
  always_comb begin
    x_ext    = {{DATA_WIDTH{bus.i_x_data[DATA_WIDTH-1]}}, bus.i_x_data};
    w_ext    = {{DATA_WIDTH{bus.i_w_data[DATA_WIDTH-1]}}, bus.i_w_data};
    prod     = x_ext * w_ext;
    bias_ext = {{(ACC_W-DATA_WIDTH){bias_q[DATA_WIDTH-1]}}, bias_q};
    biased   = acc_q + (bias_ext <<< FRAC_BITS);
    shifted  = biased >>> FRAC_BITS;
    res_sat  = 1'b0;
    res      = shifted[DATA_WIDTH-1:0];
    if (shifted > SAT_MAX) begin
      res     = SAT_MAX[DATA_WIDTH-1:0];
      res_sat = 1'b1;
    end else if (shifted < SAT_MIN) begin
      res     = SAT_MIN[DATA_WIDTH-1:0];
      res_sat = 1'b1;
    end
    // ReLU zeroing is not a saturation event, so res_sat is left alone.
    if ((RELU != 0) && res[DATA_WIDTH-1]) res = '0;
  end

  // Datapath next-state: operand capture, address walk, accumulate, result.
  always_comb begin
    len_d       = len_q;
    bias_d      = bias_q;
    addr_d      = addr_q;
    acc_d       = acc_q;
    data_d      = data_q;
    sat_d       = sat_q;
    rd_en_dly_d = rd_en;
    valid_d     = (state_q == S_FINAL);
    if (accept) begin
      len_d  = bus.i_len;
      bias_d = bus.i_bias;
      addr_d = '0;
      acc_d  = '0;
    end else if (rd_en_dly_q) begin
      acc_d = acc_q + {{(ACC_W-PROD_W){prod[PROD_W-1]}}, prod};
    end
    if (rd_en && !last_addr) addr_d = addr_q + ADDR_BITS'(1);
    if (state_q == S_FINAL) begin
      data_d = res;
      sat_d  = res_sat;
    end
  end

  // Datapath registers; reset abandons any operation in flight.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      len_q       <= '0;
      bias_q      <= '0;
      addr_q      <= '0;
      rd_en_dly_q <= 1'b0;
      acc_q       <= '0;
      data_q      <= '0;
      sat_q       <= 1'b0;
      valid_q     <= 1'b0;
    end else begin
      len_q       <= len_d;
      bias_q      <= bias_d;
      addr_q      <= addr_d;
      rd_en_dly_q <= rd_en_dly_d;
      acc_q       <= acc_d;
      data_q      <= data_d;
      sat_q       <= sat_d;
      valid_q     <= valid_d;
    end
  end

  assign bus.o_rd_en   = rd_en;
  assign bus.o_rd_addr = addr_q;
  assign bus.o_busy    = (state_q != S_IDLE);
  assign bus.o_valid   = valid_q;
  assign bus.o_data    = data_q;
  assign bus.o_sat     = sat_q;

endmodule

// File: tb/tb_hidden_neuron_mac.sv
// Directed bench for hidden_neuron_mac. Two instances share one stimulus:
// dut0 without ReLU, dut1 with ReLU. Each has its own 1-cycle-latency
// memory model that returns junk whenever no read was issued.
module tb_hidden_neuron_mac;
  localparam int DW = 32;
  localparam int AB = 5;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  hidden_neuron_mac_if #(.DATA_WIDTH(DW), .ADDR_BITS(AB)) bus0 ();
  hidden_neuron_mac_if #(.DATA_WIDTH(DW), .ADDR_BITS(AB)) bus1 ();

  hidden_neuron_mac #(.DATA_WIDTH(DW), .FRAC_BITS(16), .ADDR_BITS(AB), .RELU(0))
    dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
  hidden_neuron_mac #(.DATA_WIDTH(DW), .FRAC_BITS(16), .ADDR_BITS(AB), .RELU(1))
    dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

  logic          start;
  logic [AB:0]   len;
  logic [DW-1:0] bias;
  logic [DW-1:0] x_mem [32];
  logic [DW-1:0] w_mem [32];

  assign bus0.i_start = start;
  assign bus0.i_len   = len;
  assign bus0.i_bias  = bias;
  assign bus1.i_start = start;
  assign bus1.i_len   = len;
  assign bus1.i_bias  = bias;

  always @(posedge clk) begin
    bus0.i_x_data <= bus0.o_rd_en ? x_mem[bus0.o_rd_addr] : 32'hDEADBEEF;
    bus0.i_w_data <= bus0.o_rd_en ? w_mem[bus0.o_rd_addr] : 32'h5A5A5A5A;
    bus1.i_x_data <= bus1.o_rd_en ? x_mem[bus1.o_rd_addr] : 32'hDEADBEEF;
    bus1.i_w_data <= bus1.o_rd_en ? w_mem[bus1.o_rd_addr] : 32'h5A5A5A5A;
  end

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Launch one operation from idle (called at a negedge = cycle 0) and check
  // the read stream, busy/valid timing and the result in cycle n+3.
  task automatic run_op(input string tag, input int n, input logic [DW-1:0] b,
                        input logic [DW-1:0] exp0, input logic exp_sat0,
                        input logic [DW-1:0] exp1, input logic chk_sat1,
                        input logic exp_sat1);
    logic          exp_rd;
    logic [AB-1:0] exp_addr;
    start = 1'b1;
    len   = n[AB:0];
    bias  = b;
    tick();
    start = 1'b0;
    len   = '0;
    bias  = '0;
    for (int c = 1; c <= n + 2; c++) begin
      exp_rd   = (c <= n);
      exp_addr = exp_rd ? AB'(c - 1) : AB'(n - 1);
      check($sformatf("%s c%0d busy/valid/rd_en", tag, c),
            {bus0.o_busy, bus0.o_valid, bus0.o_rd_en, bus1.o_valid},
            {1'b1, 1'b0, exp_rd, 1'b0});
      if (n > 0) check($sformatf("%s c%0d rd_addr", tag, c), bus0.o_rd_addr, exp_addr);
      tick();
    end
    check($sformatf("%s c%0d busy/valid", tag, n + 3),
          {bus0.o_busy, bus0.o_valid, bus1.o_valid}, {1'b0, 1'b1, 1'b1});
    check({tag, " data relu0"}, bus0.o_data, exp0);
    check({tag, " sat relu0"}, bus0.o_sat, exp_sat0);
    check({tag, " data relu1"}, bus1.o_data, exp1);
    if (chk_sat1) check({tag, " sat relu1"}, bus1.o_sat, exp_sat1);
    tick();
    check({tag, " valid drop"}, {bus0.o_valid, bus1.o_valid}, 2'b00);
    check({tag, " data hold"}, bus0.o_data, exp0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic seen_valid;
    start = 1'b0;
    len   = '0;
    bias  = '0;
    rst_n = 1'b0;
    for (int i = 0; i < 32; i++) begin
      x_mem[i] = '0;
      w_mem[i] = '0;
    end
    repeat (3) tick();
    check("reset ctl", {bus0.o_busy, bus0.o_valid, bus0.o_rd_en, bus0.o_sat, bus1.o_valid},
          5'b00000);
    check("reset data", bus0.o_data, 32'h0);
    check("reset addr", bus0.o_rd_addr, 5'h0);
    rst_n = 1'b1;
    tick();

    // 1*0.5 + 2*0.25 + (-1)*2 + 0.25 = -0.75
    x_mem[0] = 32'h00010000; w_mem[0] = 32'h00008000;
    x_mem[1] = 32'h00020000; w_mem[1] = 32'h00004000;
    x_mem[2] = 32'hFFFF0000; w_mem[2] = 32'h00020000;
    run_op("basic", 3, 32'h00004000, 32'hFFFF4000, 1'b0, 32'h0, 1'b1, 1'b0);

    run_op("zero_len", 0, 32'h00030000, 32'h00030000, 1'b0, 32'h00030000, 1'b1, 1'b0);

    x_mem[0] = 32'h7FFFFFFF; w_mem[0] = 32'h7FFFFFFF;
    x_mem[1] = 32'h7FFFFFFF; w_mem[1] = 32'h7FFFFFFF;
    run_op("sat_pos", 2, 32'h0, 32'h7FFFFFFF, 1'b1, 32'h7FFFFFFF, 1'b1, 1'b1);

    x_mem[0] = 32'h80000000; w_mem[0] = 32'h7FFFFFFF;
    x_mem[1] = 32'h80000000; w_mem[1] = 32'h7FFFFFFF;
    run_op("sat_neg", 2, 32'h0, 32'h80000000, 1'b1, 32'h0, 1'b0, 1'b0);

    // -2^-16 * 2^-16 floors to -2^-16
    x_mem[0] = 32'hFFFFFFFF; w_mem[0] = 32'h00000001;
    run_op("floor", 1, 32'h0, 32'hFFFFFFFF, 1'b0, 32'h0, 1'b1, 1'b0);

    // Start handling: A = 1+2+3+4 + 0.5 = 10.5; B (len 2) = 1+2 + 1 = 4.0
    for (int i = 0; i < 4; i++) begin
      x_mem[i] = (i + 1) << 16;
      w_mem[i] = 32'h00010000;
    end
    start = 1'b1; len = 6'd4; bias = 32'h00008000;
    tick();                                       // cycle 1
    start = 1'b0;
    tick();                                       // cycle 2
    check("ign c2 busy", bus0.o_busy, 1'b1);
    start = 1'b1; len = 6'd2; bias = 32'h7FFF0000;
    tick();                                       // cycle 3
    start = 1'b0;
    tick();                                       // cycle 4
    tick();                                       // cycle 5
    start = 1'b1; len = 6'd1; bias = 32'h12340000;
    tick();                                       // cycle 6
    start = 1'b0;
    check("ign c6 valid", {bus0.o_valid, bus0.o_busy}, 2'b01);
    tick();                                       // cycle 7
    check("ign c7 valid", {bus0.o_valid, bus0.o_busy}, 2'b10);
    check("ign data relu0", bus0.o_data, 32'h000A8000);
    check("ign data relu1", bus1.o_data, 32'h000A8000);
    start = 1'b1; len = 6'd2; bias = 32'h00010000;
    tick();                                       // cycle 8
    start = 1'b0;
    check("b2b c8 read", {bus0.o_busy, bus0.o_rd_en, bus0.o_rd_addr}, {1'b1, 1'b1, 5'd0});
    seen_valid = 1'b0;
    for (int c = 9; c <= 11; c++) begin
      tick();
      seen_valid |= bus0.o_valid;
    end
    check("b2b no early valid", seen_valid, 1'b0);
    tick();                                       // cycle 12
    check("b2b c12 valid", bus0.o_valid, 1'b1);
    check("b2b data", bus0.o_data, 32'h00040000);
    tick();

    // Reset in the middle of a len=8 operation.
    start = 1'b1; len = 6'd8; bias = 32'h0;
    tick();                                       // cycle 1
    start = 1'b0;
    tick();                                       // cycle 2
    tick();                                       // cycle 3
    tick();                                       // cycle 4
    rst_n = 1'b0;
    tick();                                       // cycle 5
    check("rst ctl", {bus0.o_busy, bus0.o_valid, bus0.o_rd_en, bus0.o_sat, bus1.o_busy},
          5'b00000);
    check("rst data", {bus0.o_data, bus1.o_data}, 64'h0);
    check("rst addr", bus0.o_rd_addr, 5'h0);
    rst_n = 1'b1;
    seen_valid = 1'b0;
    for (int c = 0; c < 10; c++) begin
      tick();
      seen_valid |= bus0.o_valid | bus1.o_valid;
    end
    check("rst no valid", seen_valid, 1'b0);

    x_mem[0] = 32'h00010000; w_mem[0] = 32'h00010000;
    run_op("post_rst", 1, 32'h0, 32'h00010000, 1'b0, 32'h00010000, 1'b1, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
